// File: rtl/reg_file_frames.sv
// rtl/reg_file_frames.sv - register file with a LIFO stack of whole-register-set frames
// Two registered read ports, two write ports, one-cycle backup (push) and restore (pop).
module reg_file_frames #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             RegR1,
    input  logic             RegR2,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             RegW1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             RegW2,
    input  logic [AW-1:0]    waddr2,
    input  logic [WIDTH-1:0] wdata2,
    input  logic             backup,
    input  logic             restore,
    output logic [AW:0]      depth,
    output logic             overflow,
    output logic             underflow,
    output logic             cmd_err
);

    localparam int          FW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs   [NREGS];
    logic [WIDTH-1:0] frames [DEPTH][NREGS];

    logic          both_cmd;
    logic          push;
    logic          pop;
    logic          push_full;
    logic          pop_empty;
    logic [AW:0]   depth_m1;
    logic [FW-1:0] push_idx;
    logic [FW-1:0] pop_idx;

    // Simultaneous backup+restore is a control-unit error: neither stack operation happens.
    always_comb begin
        both_cmd  = backup & restore;
        push      = backup & ~restore & (depth != DEPTH_MAX);
        pop       = restore & ~backup & (depth != '0);
        push_full = backup & ~restore & (depth == DEPTH_MAX);
        pop_empty = restore & ~backup & (depth == '0);
        depth_m1  = depth - 1'b1;
        push_idx  = depth[FW-1:0];
        pop_idx   = depth_m1[FW-1:0];
    end

    // Live registers: a pop replaces the whole set and drops same-cycle writes;
    // otherwise port 2 is applied last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (pop) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= frames[pop_idx][i];
            end
        end else begin
            if (RegW1) begin
                regs[waddr1] <= wdata1;
            end
            if (RegW2) begin
                regs[waddr2] <= wdata2;
            end
        end
    end

    // Frame storage needs no reset; only frames below depth are ever read.
    always_ff @(posedge clk) begin
        if (!Reset && push) begin
            for (int i = 0; i < NREGS; i++) begin
                frames[push_idx][i] <= regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (RegR1) begin
                rdata1 <= regs[raddr1];
            end
            if (RegR2) begin
                rdata2 <= regs[raddr2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            if (push) begin
                depth <= depth + 1'b1;
            end else if (pop) begin
                depth <= depth_m1;
            end
            overflow  <= overflow  | push_full;
            underflow <= underflow | pop_empty;
            cmd_err   <= cmd_err   | both_cmd;
        end
    end

endmodule

// File: tb/tb_reg_file_frames.sv
// tb/tb_reg_file_frames.sv - directed self-checking bench for reg_file_frames
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_reg_file_frames;

    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic             RegR1, RegR2;
    logic [AW-1:0]    raddr1, raddr2;
    logic [WIDTH-1:0] rdata1, rdata2;
    logic             RegW1, RegW2;
    logic [AW-1:0]    waddr1, waddr2;
    logic [WIDTH-1:0] wdata1, wdata2;
    logic             backup, restore;
    logic [AW:0]      depth;
    logic             overflow, underflow, cmd_err;

    int vectors     = 0;
    int miscompares = 0;

    reg_file_frames #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .Reset(Reset),
        .RegR1(RegR1), .RegR2(RegR2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .RegW1(RegW1), .waddr1(waddr1), .wdata1(wdata1),
        .RegW2(RegW2), .waddr2(waddr2), .wdata2(wdata2),
        .backup(backup), .restore(restore), .depth(depth),
        .overflow(overflow), .underflow(underflow), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegR1 = 0; RegR2 = 0; raddr1 = '0; raddr2 = '0;
        RegW1 = 0; RegW2 = 0; waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0;
        backup = 0; restore = 0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        RegW1 = 1; waddr1 = a; wdata1 = d;
        step();
        RegW1 = 0;
    endtask

    task automatic rd1(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
        RegR1 = 1; raddr1 = a;
        step();
        RegR1 = 0;
        chk(tag, 32'(rdata1), 32'(exp));
    endtask

    task automatic cmd(input logic b, input logic r);
        backup = b; restore = r;
        step();
        backup = 0; restore = 0;
    endtask

    task automatic flags(input string tag, input logic [AW:0] d, input logic [2:0] f);
        chk({tag, "_depth"}, 32'(depth), 32'(d));
        chk({tag, "_flags"}, {29'd0, overflow, underflow, cmd_err}, {29'd0, f});
    endtask

    initial begin
        clear_inputs();
        Reset = 1;
        step();
        step();
        Reset = 0;
        flags("reset", 0, 3'b000);
        chk("reset_rdata1", 32'(rdata1), 32'h0);
        chk("reset_rdata2", 32'(rdata2), 32'h0);

        // Read latency and hold
        RegW2 = 1; waddr2 = 4'd3; wdata2 = 16'h1234;
        step();
        RegW2 = 0;
        rd1("r3_read", 4'd3, 16'h1234);
        raddr1 = 4'd0;
        step();
        chk("r3_hold", 32'(rdata1), 32'h1234);

        // No write bypass: same-cycle read of r4 sees the old value
        RegW1 = 1; waddr1 = 4'd4; wdata1 = 16'h7777;
        RegR2 = 1; raddr2 = 4'd4;
        step();
        clear_inputs();
        chk("no_bypass", 32'(rdata2), 32'h0);
        rd1("r4_read", 4'd4, 16'h7777);

        // Port 2 wins a collision
        RegW1 = 1; waddr1 = 4'd5; wdata1 = 16'hAAAA;
        RegW2 = 1; waddr2 = 4'd5; wdata2 = 16'h5555;
        step();
        clear_inputs();
        rd1("collide_r5", 4'd5, 16'h5555);

        // Backup with same-cycle write, then restore
        wr1(4'd1, 16'h0011);
        backup = 1; RegW2 = 1; waddr2 = 4'd1; wdata2 = 16'h2222;
        step();
        clear_inputs();
        flags("bk1", 1, 3'b000);
        rd1("bk1_r1", 4'd1, 16'h2222);
        cmd(0, 1);
        flags("rs1", 0, 3'b000);
        rd1("rs1_r1", 4'd1, 16'h0011);

        // Fill the stack, overflow, then LIFO replay and underflow
        for (int i = 0; i < DEPTH; i++) begin
            wr1(4'd6, 16'h6000 + 16'(i));
            cmd(1, 0);
        end
        flags("full", 4, 3'b000);
        wr1(4'd6, 16'h6004);
        cmd(1, 0);
        flags("ovf", 4, 3'b100);
        RegR1 = 1; raddr1 = 4'd6;
        cmd(0, 1);
        RegR1 = 0;
        chk("read_in_restore", 32'(rdata1), 32'h6004);
        rd1("pop0_r6", 4'd6, 16'h6003);
        cmd(0, 1);
        rd1("pop1_r6", 4'd6, 16'h6002);
        cmd(0, 1);
        rd1("pop2_r6", 4'd6, 16'h6001);
        cmd(0, 1);
        rd1("pop3_r6", 4'd6, 16'h6000);
        flags("empty", 0, 3'b100);
        RegW1 = 1; waddr1 = 4'd7; wdata1 = 16'h7070;
        cmd(0, 1);
        RegW1 = 0;
        flags("unf", 0, 3'b110);
        rd1("unf_r6", 4'd6, 16'h6000);
        rd1("unf_write_r7", 4'd7, 16'h7070);

        // backup+restore together at depth 1
        cmd(1, 0);
        flags("pre_cmderr", 1, 3'b110);
        RegW2 = 1; waddr2 = 4'd8; wdata2 = 16'h8888;
        cmd(1, 1);
        RegW2 = 0;
        flags("cmderr", 1, 3'b111);
        rd1("cmderr_r8", 4'd8, 16'h8888);
        rd1("cmderr_r6", 4'd6, 16'h6000);
        cmd(0, 1);
        flags("cmderr_pop", 0, 3'b111);
        rd1("cmderr_pop_r8", 4'd8, 16'h0000);

        // Restore beats a same-cycle write
        wr1(4'd2, 16'h0202);
        cmd(1, 0);
        RegW2 = 1; waddr2 = 4'd2; wdata2 = 16'hBEEF;
        cmd(0, 1);
        RegW2 = 0;
        flags("rs_beats_w", 0, 3'b111);
        rd1("rs_beats_w_r2", 4'd2, 16'h0202);

        // Reset mid-stack
        cmd(1, 0);
        cmd(1, 0);
        cmd(1, 0);
        flags("mid", 3, 3'b111);
        RegR1 = 1; raddr1 = 4'd3;
        RegR2 = 1; raddr2 = 4'd5;
        step();
        chk("pre_rst_rdata2", 32'(rdata2), 32'h5555);
        Reset = 1; RegW1 = 1; waddr1 = 4'd9; wdata1 = 16'h9999; backup = 1;
        step();
        Reset = 0;
        clear_inputs();
        flags("mid_rst", 0, 3'b000);
        chk("mid_rst_rdata1", 32'(rdata1), 32'h0);
        chk("mid_rst_rdata2", 32'(rdata2), 32'h0);
        rd1("mid_rst_r3", 4'd3, 16'h0);
        rd1("mid_rst_r6", 4'd6, 16'h0);
        rd1("mid_rst_r9", 4'd9, 16'h0);
        cmd(0, 1);
        flags("post_rst_unf", 0, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
